serial_frame_tx: RTL and testbench



---
 rtl/serial_tx_pkg.sv | 31 +++
 rtl/serial_frame_tx_if.sv | 29 ++
 rtl/serial_tx_fifo.sv | 67 ++++++
 rtl/serial_frame_tx.sv | 207 ++++++++++++++++++++
 tb/tb_serial_frame_tx.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial frame transmitter.
// Optional ACK checking is enabled by defining SERIAL_TX_ACK_CHECK_EN.
package serial_tx_pkg;

  localparam int unsigned DEF_ADDR_W     = 7;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_CLK_DIV    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_STOP_LO,
    ST_STOP_HI
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Host-side and serial-line signals of serial_frame_tx, bundled with
// master (driver) and slave (transmitter) views.
interface serial_frame_tx_if #(
  parameter int unsigned ADDR_W = serial_tx_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = serial_tx_pkg::DEF_DATA_W
);
  logic              go;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic              busy;
  logic              done;
  logic              ack_err;
  logic              out_d;
  logic              out_d_oe;
  logic              out_c;
  logic              in_d;

  modport master (
    output go, addr, wr_data, wr_valid, in_d,
    input  wr_ready, busy, done, ack_err, out_d, out_d_oe, out_c
  );

  modport slave (
    input  go, addr, wr_data, wr_valid, in_d,
    output wr_ready, busy, done, ack_err, out_d, out_d_oe, out_c
  );
endinterface

// File: rtl/serial_tx_fifo.sv
// Synchronous data-word FIFO for serial_frame_tx; writes are dropped when
// full regardless of a simultaneous read.
module serial_tx_fifo
  import serial_tx_pkg::*;
#(
  parameter  int unsigned DATA_W     = DEF_DATA_W,
  parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned PTR_W      = clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W      = PTR_W + 1
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: START, address, ACK slot, buffered data words
// each with an ACK slot, STOP. NACK handling is built when
// SERIAL_TX_ACK_CHECK_EN is defined; otherwise ACK slots are ignored.
module serial_frame_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV
) (
  input logic              clk_in,
  input logic              reset_n,
  serial_frame_tx_if.slave bus
);

  localparam int unsigned PH_W = clog2(CLK_DIV) + 1;
  localparam int unsigned SH_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned BC_W = clog2(SH_W) + 1;

  localparam logic [PH_W-1:0] HALF     = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] HALF_END = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] CELL_END = PH_W'(2 * CLK_DIV - 1);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic              done_q, done_d;

  logic              cell_end, half_end;
  logic              accept_go, ack_decide, nack, pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [clog2(FIFO_DEPTH):0] unused_fifo_count;
  logic              out_c, out_d, out_d_oe;

  serial_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .wr_en   (bus.wr_valid),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (unused_fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cell_end   = (phase_q == CELL_END);
  assign half_end   = (phase_q == HALF_END);
  assign accept_go  = (state_q == ST_IDLE) && bus.go;
  assign ack_decide = ((state_q == ST_ADDR_ACK) || (state_q == ST_DATA_ACK)) && cell_end;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.go) begin
          state_d  = ST_START;
          phase_d  = '0;
          shift_d  = SH_W'(bus.addr) << (SH_W - ADDR_W);
          bitcnt_d = BC_W'(ADDR_W - 1);
        end
      end
      ST_START, ST_STOP_LO: begin
        if (half_end) begin
          phase_d = '0;
          state_d = (state_q == ST_START) ? ST_ADDR : ST_STOP_HI;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_ADDR, ST_DATA: begin
        if (cell_end) begin
          phase_d = '0;
          shift_d = {shift_q[SH_W-2:0], 1'b0};
          if (bitcnt_q == '0) begin
            state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
          end else begin
            bitcnt_d = bitcnt_q - BC_W'(1);
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_ADDR_ACK, ST_DATA_ACK: begin
        if (cell_end) begin
          phase_d = '0;
          if (nack || fifo_empty) begin
            state_d = ST_STOP_LO;
          end else begin
            // Head word is loaded on the slot's last cycle so DATA starts aligned.
            pop      = 1'b1;
            shift_d  = SH_W'(fifo_rd_data) << (SH_W - DATA_W);
            bitcnt_d = BC_W'(DATA_W - 1);
            state_d  = ST_DATA;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_STOP_HI: begin
        if (half_end) begin
          phase_d = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
    end
  end

`ifdef SERIAL_TX_ACK_CHECK_EN
  logic ack_err_q, ack_err_d;

  assign nack = bus.in_d;

  always_comb begin
    ack_err_d = ack_err_q;
    if (accept_go)                ack_err_d = 1'b0;
    else if (ack_decide && nack)  ack_err_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) ack_err_q <= 1'b0;
    else          ack_err_q <= ack_err_d;
  end

  assign bus.ack_err = ack_err_q;
`else
  logic unused_ack_inputs;

  assign unused_ack_inputs = bus.in_d ^ accept_go ^ ack_decide;
  assign nack              = 1'b0;
  assign bus.ack_err       = 1'b0;
`endif

  // Line levels derive from registered state only, so reset forces idle levels at once.
  always_comb begin
    out_c    = 1'b1;
    out_d    = 1'b1;
    out_d_oe = 1'b1;
    case (state_q)
      ST_START: begin
        out_c = 1'b1;
        out_d = 1'b0;
      end
      ST_ADDR, ST_DATA: begin
        out_c = (phase_q >= HALF);
        out_d = shift_q[SH_W-1];
      end
      ST_ADDR_ACK, ST_DATA_ACK: begin
        out_c    = (phase_q >= HALF);
        out_d    = 1'b1;
        out_d_oe = 1'b0;
      end
      ST_STOP_LO: begin
        out_c = 1'b0;
        out_d = 1'b0;
      end
      ST_STOP_HI: begin
        out_c = 1'b1;
        out_d = 1'b0;
      end
      default: begin
        out_c    = 1'b1;
        out_d    = 1'b1;
        out_d_oe = 1'b1;
      end
    endcase
  end

  assign bus.out_c    = out_c;
  assign bus.out_d    = out_d;
  assign bus.out_d_oe = out_d_oe;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.wr_ready = !fifo_full;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: decodes the serial line into bit
// cells and compares frames, timing and flags against a queue-based model.
module tb_serial_frame_tx;

  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CLK_DIV = 2;
`ifdef SERIAL_TX_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic clk_in;
  logic reset_n;

  serial_frame_tx_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  serial_frame_tx #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Model of FIFO contents, in push order.
  logic [DATA_W-1:0] mq[$];

  // Serial-line monitor state: decoded cells (0/1, 2 = released), conditions seen.
  int rx[$];
  int n_start = 0;
  int n_stop  = 0;
  int n_glitch = 0;
  int nack_slot = 99;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic int frame_cycles(input int n);
    return CLK_DIV * (1 + 2 * (ADDR_W + 1) + 2 * n * (DATA_W + 1) + 2);
  endfunction

  initial begin
    logic pc, pd, poe, c, d, oe;
    int slot;
    pc = 1; pd = 1; poe = 1; slot = 0;
    bus.in_d = 1'b0;
    forever begin
      @(negedge clk_in);
      c = bus.out_c; d = bus.out_d; oe = bus.out_d_oe;
      if (!reset_n) begin
        pc = 1; pd = 1; poe = 1; slot = 0;
        bus.in_d = 1'b0;
      end else begin
        if (pc && c && pd && !d) begin
          n_start++;
          rx.delete();
          slot = 0;
        end else if (pc && c && !pd && d) begin
          n_stop++;
        end else if ((d != pd) && !(pc && !c)) begin
          n_glitch++;
        end
        if (!pc && c) rx.push_back(oe ? int'(d) : 2);
        if (!poe && oe) slot++;
        bus.in_d = !oe && (slot == nack_slot);
        pc = c; pd = d; poe = oe;
      end
    end
  end

  task automatic push(input logic [DATA_W-1:0] w);
    check("wr_ready", bus.wr_ready, mq.size() < DEPTH);
    bus.wr_valid = 1'b1;
    bus.wr_data  = w;
    @(posedge clk_in); #1;
    bus.wr_valid = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(w);
  endtask

  task automatic start_go(input logic [ADDR_W-1:0] a);
    bus.go   = 1'b1;
    bus.addr = a;
    @(posedge clk_in); #1;
    bus.go = 1'b0;
  endtask

  // Runs one frame from the model FIFO; returns measured cycles/ack_err and
  // the model's words-sent count and expected error flag.
  task automatic do_frame(input logic [ADDR_W-1:0] a, input int nack_at,
                          input bit mid_push, input logic [DATA_W-1:0] mid_w,
                          input bit busy_go, output int cyc, output logic err,
                          output int sent, output bit exp_err);
    int exp_bits[$];
    logic [DATA_W-1:0] w;
    int s0, p0, g0;
    bit ok;
    if (mid_push) mq.push_back(mid_w);
    exp_err = ACK_CHK && (nack_at <= mq.size());
    sent    = exp_err ? nack_at : mq.size();
    exp_bits = {};
    for (int i = ADDR_W - 1; i >= 0; i--) exp_bits.push_back(int'(a[i]));
    exp_bits.push_back(2);
    for (int j = 0; j < sent; j++) begin
      w = mq.pop_front();
      for (int b = DATA_W - 1; b >= 0; b--) exp_bits.push_back(int'(w[b]));
      exp_bits.push_back(2);
    end
    exp_bits.push_back(0);  // clock rise entering stop-high, data held low
    nack_slot = nack_at;
    s0 = n_start; p0 = n_stop; g0 = n_glitch;
    start_go(a);
    cyc = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk_in);
      if (!bus.busy) break;
      cyc++;
      @(posedge clk_in); #1;
      bus.wr_valid = mid_push && (cyc == 40);
      bus.wr_data  = mid_w;
      bus.go       = busy_go && (cyc == 10);
      bus.addr     = ~a;
    end
    bus.wr_valid = 1'b0;
    bus.go       = 1'b0;
    check("frame_end", bus.busy, 1'b0);
    check("done_pulse", bus.done, 1'b1);
    err = bus.ack_err;
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check("done_width", bus.done, 1'b0);
    check("idle_after", bus.busy, 1'b0);
    ok = (rx.size() == exp_bits.size());
    for (int i = 0; ok && i < exp_bits.size(); i++) if (rx[i] != exp_bits[i]) ok = 0;
    if (!ok) $display("INFO rx cells %0d, expected %0d", rx.size(), exp_bits.size());
    check("frame_bits", ok, 1'b1);
    check("start_count", n_start - s0, 1);
    check("stop_count", n_stop - p0, 1);
    check("data_edges", n_glitch - g0, 0);
    nack_slot = 99;
    @(posedge clk_in); #1;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                nwords;
    logic [DATA_W-1:0] w0;
    int                nack_at;
    int                exp_cycles;
    bit                exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cyc, sent;
    logic err;
    bit xerr;
    bus.go = 0; bus.addr = '0; bus.wr_data = '0; bus.wr_valid = 0;

    // Cycle counts at CLK_DIV=2: 38 + 36 per data word.
    vecs[0] = '{7'h5A, 1, 8'hC3, 99, 74, 1'b0};
`ifdef SERIAL_TX_ACK_CHECK_EN
    vecs[1] = '{7'h5A, 1, 8'hC3, 0, 38, 1'b1};
    vecs[2] = '{7'h11, 0, 8'h00, 99, 74, 1'b0};
    vecs[3] = '{7'h7F, 2, 8'h81, 1, 74, 1'b1};
    vecs[4] = '{7'h00, 0, 8'h00, 99, 74, 1'b0};
`else
    vecs[1] = '{7'h5A, 1, 8'hC3, 0, 74, 1'b0};
    vecs[2] = '{7'h11, 0, 8'h00, 99, 38, 1'b0};
    vecs[3] = '{7'h7F, 2, 8'h81, 1, 110, 1'b0};
    vecs[4] = '{7'h00, 0, 8'h00, 99, 38, 1'b0};
`endif

    reset_n = 1'b0;
    #23;
    check("rst_out_c", bus.out_c, 1'b1);
    check("rst_out_d", bus.out_d, 1'b1);
    check("rst_oe", bus.out_d_oe, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_ack_err", bus.ack_err, 1'b0);
    check("rst_wr_ready", bus.wr_ready, 1'b1);
    reset_n = 1'b1;
    @(posedge clk_in); #1;

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].nwords; i++) push(vecs[v].w0 + DATA_W'(i * 17));
      do_frame(vecs[v].addr, vecs[v].nack_at, 0, '0, 0, cyc, err, sent, xerr);
      check($sformatf("vec%0d_cycles", v), cyc, vecs[v].exp_cycles);
      check($sformatf("vec%0d_ack_err", v), err, vecs[v].exp_err);
    end

    // Full FIFO: fifth push dropped, frame carries exactly four words.
    for (int i = 0; i < 5; i++) push(8'h10 + DATA_W'(i));
    check("full_wr_ready", bus.wr_ready, 1'b0);
    do_frame(7'h33, 99, 0, '0, 0, cyc, err, sent, xerr);
    check("full_sent", sent, 4);
    check("full_cycles", cyc, frame_cycles(4));

    // Word pushed during the first DATA phase extends the same frame.
    push(8'hA5);
    do_frame(7'h2C, 99, 1, 8'h3C, 0, cyc, err, sent, xerr);
    check("extend_cycles", cyc, frame_cycles(2));

    // go while busy is ignored; empty FIFO gives an address-only frame.
    do_frame(7'h46, 99, 0, '0, 1, cyc, err, sent, xerr);
    check("addr_only_cycles", cyc, frame_cycles(0));

    // Reset in the middle of a data word.
    push(8'hE1);
    push(8'h1E);
    start_go(7'h55);
    repeat (40) @(posedge clk_in);
    #1;
    check("pre_rst_busy", bus.busy, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_c", bus.out_c, 1'b1);
    check("mid_rst_out_d", bus.out_d, 1'b1);
    check("mid_rst_oe", bus.out_d_oe, 1'b1);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_wr_ready", bus.wr_ready, 1'b1);
    mq.delete();
    #14;
    reset_n = 1'b1;
    @(posedge clk_in); #1;
    do_frame(7'h0F, 99, 0, '0, 0, cyc, err, sent, xerr);
    check("post_rst_cycles", cyc, frame_cycles(0));

    // Randomised frames against the model.
    for (int it = 0; it < 15; it++) begin
      int n, nk;
      logic [ADDR_W-1:0] a;
      n = (mq.size() >= DEPTH) ? 0 : $urandom_range(DEPTH - mq.size(), 0);
      for (int i = 0; i < n; i++) push(DATA_W'($urandom));
      a  = ADDR_W'($urandom);
      nk = $urandom_range(6, 0);
      do_frame(a, nk, 0, '0, 0, cyc, err, sent, xerr);
      check($sformatf("rnd%0d_cycles", it), cyc, frame_cycles(sent));
      check($sformatf("rnd%0d_ack_err", it), err, xerr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
